// File: rtl/mez_pkg.sv
// Shared types and constants for the mezzanine IDE/FPU bus controller.
package mez_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StAck,
        StRecov
    } ide_state_e;

    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    localparam logic [1:0] FC_CPU = 2'b11;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mez_bus_watchdog.sv
// Bus-timeout watchdog: counts consecutive unclaimed nAS-low cycles and pulses on expiry.
module mez_bus_watchdog
    import mez_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       as_n,
    input  logic [1:0] dsack_n,
    input  logic       berr_active,
    output logic       expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        // A claimed cycle (any DSACK bit low) restarts the consecutive count.
        if (as_n || (dsack_n != DSACK_NONE)) begin
            cnt_d = '0;
        end else if (!berr_active) begin
            cnt_d   = cnt_q + 1'b1;
            expired = (cnt_q == CntW'(TIMEOUT_CYC - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mez_ide_bus_ctl.sv
// 68030-to-IDE PIO cycle controller with FPU chip select and bus-error generation.
// Optional bus-timeout watchdog enabled by defining MEZ_BUS_WATCHDOG_EN.
module mez_ide_bus_ctl
    import mez_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned STROBE_CYC  = 6,
    parameter int unsigned RECOV_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 128,
    parameter logic [6:0]  FPU_SEL     = 7'b0010001
) (
    input  logic       sysClk,
    input  logic       sysReset,
    input  logic       nAS,
    input  logic       nDS,
    input  logic       RnW,
    input  logic [1:0] cpuFC,
    input  logic [6:0] addrSel,
    input  logic       nIdeCE,
    input  logic       nIdeIO16,
    input  logic       nFpuSense,
    input  logic [1:0] nDsackIn,
    output logic       nIORd,
    output logic       nIOWr,
    output logic       nIdeCS1,
    output logic       nIdeCS3,
    output logic       nIdeBufEn,
    output logic [1:0] nDsackOut,
    output logic       dsackOe,
    output logic       berrOe,
    output logic       nFpuCE
);

    localparam int unsigned MaxCyc = max3(SETUP_CYC, STROBE_CYC, RECOV_CYC);
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYC - 1);
    localparam logic [CntW-1:0] RecovLd  = CntW'(RECOV_CYC - 1);

    ide_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cs3_q, cs3_d;
    logic            rnw_q, rnw_d;
    logic            io16_n_q, io16_n_d;
    logic            fpu_ce_n_q;
    logic            berr_q;
    logic            wd_expired;

    logic fpu_hit;
    logic ide_start;

    assign fpu_hit   = !nAS && (cpuFC == FC_CPU) && (addrSel == FPU_SEL);
    assign ide_start = !nAS && !nIdeCE && (cpuFC != FC_CPU) && !fpu_hit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cs3_d    = cs3_q;
        rnw_d    = rnw_q;
        io16_n_d = io16_n_q;
        unique case (state_q)
            StIdle: begin
                if (ide_start) begin
                    state_d = StSetup;
                    cnt_d   = SetupLd;
                    cs3_d   = addrSel[0];
                    rnw_d   = RnW;
                end
            end
            StSetup: begin
                if (nAS) begin
                    state_d = StRecov;
                    cnt_d   = RecovLd;
                end else if (cnt_q == '0) begin
                    state_d  = StStrobe;
                    cnt_d    = StrobeLd;
                    io16_n_d = nIdeIO16;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStrobe: begin
                if (nAS) begin
                    state_d = StRecov;
                    cnt_d   = RecovLd;
                end else if (cnt_q == '0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAck: begin
                if (nAS) begin
                    state_d = StRecov;
                    cnt_d   = RecovLd;
                end
            end
            StRecov: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            cs3_q    <= 1'b0;
            rnw_q    <= 1'b1;
            io16_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cs3_q    <= cs3_d;
            rnw_q    <= rnw_d;
            io16_n_q <= io16_n_d;
        end
    end

    // Outputs decode purely from registered state, so they change only on clock edges.
    always_comb begin
        logic active;
        logic strobe;
        active    = (state_q != StIdle);
        strobe    = (state_q == StStrobe) || (state_q == StAck);
        nIdeCS1   = !(active && !cs3_q);
        nIdeCS3   = !(active && cs3_q);
        nIdeBufEn = !active;
        nIORd     = !(strobe && rnw_q);
        nIOWr     = !(strobe && !rnw_q);
        dsackOe   = (state_q == StAck);
        nDsackOut = DSACK_NONE;
        if (state_q == StAck) begin
            nDsackOut = io16_n_q ? DSACK_8 : DSACK_16;
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            fpu_ce_n_q <= 1'b1;
            berr_q     <= 1'b0;
        end else if (nAS) begin
            fpu_ce_n_q <= 1'b1;
            berr_q     <= 1'b0;
        end else begin
            if (fpu_hit) begin
                fpu_ce_n_q <= 1'b0;
            end
            if ((fpu_hit && nFpuSense) || wd_expired) begin
                berr_q <= 1'b1;
            end
        end
    end

    assign nFpuCE = fpu_ce_n_q;
    assign berrOe = berr_q;

    logic unused_in;
`ifdef MEZ_BUS_WATCHDOG_EN
    mez_bus_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk         (sysClk),
        .rst         (sysReset),
        .as_n        (nAS),
        .dsack_n     (nDsackIn),
        .berr_active (berr_q),
        .expired     (wd_expired)
    );
    assign unused_in = nDS;
`else
    assign wd_expired = 1'b0;
    assign unused_in  = ^{nDS, nDsackIn, TIMEOUT_CYC[0]};
`endif

endmodule

// File: tb/tb_mez_ide_bus_ctl.sv
// Table-driven bench for mez_ide_bus_ctl; MEZ_BUS_WATCHDOG_EN adds the timeout checks.
module tb_mez_ide_bus_ctl;

`ifdef MEZ_BUS_WATCHDOG_EN
    localparam int unsigned TbTimeout = 16;
`else
    localparam int unsigned TbTimeout = 128;
`endif

    typedef struct packed {
        logic [1:0] fc;
        logic [6:0] sel;
        logic       ce_n;
        logic       io16_n;
        logic       rnw;
        logic       sense_n;
    } preset_t;

    typedef struct {
        string      tag;
        logic       rst;
        logic       nas;
        preset_t    p;
        logic [9:0] exp;
    } vec_t;

    // {fc, sel, ce_n, io16_n, rnw, sense_n}
    localparam preset_t P_RD16   = {2'b01, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam preset_t P_WR8    = {2'b01, 7'b0000001, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam preset_t P_FPU    = {2'b11, 7'b0010001, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam preset_t P_NOFPU  = {2'b11, 7'b0010001, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam preset_t P_FPUIDE = {2'b11, 7'b0010001, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam preset_t P_CPUSP  = {2'b11, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam preset_t P_NOIDE  = {2'b01, 7'b0000000, 1'b1, 1'b1, 1'b1, 1'b0};

    // {nIORd, nIOWr, nIdeCS1, nIdeCS3, nIdeBufEn, nDsackOut[1:0], dsackOe, berrOe, nFpuCE}
    localparam logic [9:0] O_IDLE  = 10'b1_1_1_1_1_11_0_0_1;
    localparam logic [9:0] O_CS1   = 10'b1_1_0_1_0_11_0_0_1;
    localparam logic [9:0] O_RD    = 10'b0_1_0_1_0_11_0_0_1;
    localparam logic [9:0] O_RD16  = 10'b0_1_0_1_0_01_1_0_1;
    localparam logic [9:0] O_CS3   = 10'b1_1_1_0_0_11_0_0_1;
    localparam logic [9:0] O_WR3   = 10'b1_0_1_0_0_11_0_0_1;
    localparam logic [9:0] O_WR8   = 10'b1_0_1_0_0_10_1_0_1;
    localparam logic [9:0] O_FPU   = 10'b1_1_1_1_1_11_0_0_0;
    localparam logic [9:0] O_FBERR = 10'b1_1_1_1_1_11_0_1_0;

    logic       sysClk = 1'b0;
    logic       sysReset, nAS, nDS, RnW, nIdeCE, nIdeIO16, nFpuSense;
    logic [1:0] cpuFC, nDsackIn;
    logic [6:0] addrSel;
    logic       nIORd, nIOWr, nIdeCS1, nIdeCS3, nIdeBufEn, dsackOe, berrOe, nFpuCE;
    logic [1:0] nDsackOut;
    logic [9:0] outs;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    always #5 sysClk = ~sysClk;

    assign outs = {nIORd, nIOWr, nIdeCS1, nIdeCS3, nIdeBufEn, nDsackOut, dsackOe, berrOe, nFpuCE};

    mez_ide_bus_ctl #(
        .SETUP_CYC   (2),
        .STROBE_CYC  (6),
        .RECOV_CYC   (2),
        .TIMEOUT_CYC (TbTimeout),
        .FPU_SEL     (7'b0010001)
    ) dut (
        .sysClk    (sysClk),
        .sysReset  (sysReset),
        .nAS       (nAS),
        .nDS       (nDS),
        .RnW       (RnW),
        .cpuFC     (cpuFC),
        .addrSel   (addrSel),
        .nIdeCE    (nIdeCE),
        .nIdeIO16  (nIdeIO16),
        .nFpuSense (nFpuSense),
        .nDsackIn  (nDsackIn),
        .nIORd     (nIORd),
        .nIOWr     (nIOWr),
        .nIdeCS1   (nIdeCS1),
        .nIdeCS3   (nIdeCS3),
        .nIdeBufEn (nIdeBufEn),
        .nDsackOut (nDsackOut),
        .dsackOe   (dsackOe),
        .berrOe    (berrOe),
        .nFpuCE    (nFpuCE)
    );

    task automatic add_n(input int n, input string tag, input logic rst, input logic nas,
                         input preset_t p, input logic [9:0] exp);
        vec_t v;
        v.tag = tag;
        v.rst = rst;
        v.nas = nas;
        v.p   = p;
        v.exp = exp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic nas, input preset_t p);
        sysReset  = rst;
        nAS       = nas;
        nDS       = nas;
        cpuFC     = p.fc;
        addrSel   = p.sel;
        nIdeCE    = p.ce_n;
        nIdeIO16  = p.io16_n;
        RnW       = p.rnw;
        nFpuSense = p.sense_n;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0b want %0b", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge sysClk);
        #1;
    endtask

    initial begin
        int  k;
        bit  seen;

        drive(1'b1, 1'b1, P_RD16);
        nDsackIn = 2'b11;

        add_n(2, "reset",        1'b1, 1'b1, P_RD16,   O_IDLE);
        add_n(1, "idle",         1'b0, 1'b1, P_RD16,   O_IDLE);
        add_n(2, "rd_setup",     1'b0, 1'b0, P_RD16,   O_CS1);
        add_n(6, "rd_strobe",    1'b0, 1'b0, P_RD16,   O_RD);
        add_n(2, "rd_ack16",     1'b0, 1'b0, P_RD16,   O_RD16);
        add_n(2, "rd_recov",     1'b0, 1'b1, P_RD16,   O_CS1);
        add_n(1, "rd_done",      1'b0, 1'b1, P_RD16,   O_IDLE);
        add_n(2, "wr_setup",     1'b0, 1'b0, P_WR8,    O_CS3);
        add_n(6, "wr_strobe",    1'b0, 1'b0, P_WR8,    O_WR3);
        add_n(1, "wr_ack8",      1'b0, 1'b0, P_WR8,    O_WR8);
        add_n(2, "wr_recov",     1'b0, 1'b1, P_WR8,    O_CS3);
        add_n(1, "wr_done",      1'b0, 1'b1, P_WR8,    O_IDLE);
        add_n(1, "ab_setup",     1'b0, 1'b0, P_RD16,   O_CS1);
        add_n(2, "ab_recov",     1'b0, 1'b1, P_RD16,   O_CS1);
        add_n(1, "ab_done",      1'b0, 1'b1, P_RD16,   O_IDLE);
        add_n(2, "abs_setup",    1'b0, 1'b0, P_RD16,   O_CS1);
        add_n(2, "abs_strobe",   1'b0, 1'b0, P_RD16,   O_RD);
        add_n(2, "abs_recov",    1'b0, 1'b1, P_RD16,   O_CS1);
        add_n(1, "abs_done",     1'b0, 1'b1, P_RD16,   O_IDLE);
        add_n(1, "nm_setup",     1'b0, 1'b0, P_RD16,   O_CS1);
        add_n(1, "nm_recov",     1'b0, 1'b1, P_RD16,   O_CS1);
        add_n(1, "nm_recov2",    1'b0, 1'b0, P_RD16,   O_CS1);
        add_n(1, "nm_gap",       1'b0, 1'b0, P_RD16,   O_IDLE);
        add_n(1, "nm_restart",   1'b0, 1'b0, P_RD16,   O_CS1);
        add_n(2, "nm_recov3",    1'b0, 1'b1, P_RD16,   O_CS1);
        add_n(1, "nm_done",      1'b0, 1'b1, P_RD16,   O_IDLE);
        add_n(2, "fpu_ce",       1'b0, 1'b0, P_FPU,    O_FPU);
        add_n(1, "fpu_off",      1'b0, 1'b1, P_FPU,    O_IDLE);
        add_n(2, "fpu_berr",     1'b0, 1'b0, P_NOFPU,  O_FBERR);
        add_n(1, "fpu_berr_off", 1'b0, 1'b1, P_NOFPU,  O_IDLE);
        add_n(2, "fpu_wins",     1'b0, 1'b0, P_FPUIDE, O_FPU);
        add_n(1, "fpu_wins_off", 1'b0, 1'b1, P_FPUIDE, O_IDLE);
        add_n(3, "cpu_space",    1'b0, 1'b0, P_CPUSP,  O_IDLE);
        add_n(1, "cpu_space_off",1'b0, 1'b1, P_CPUSP,  O_IDLE);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge sysClk);
            drive(vecs[i].rst, vecs[i].nas, vecs[i].p);
            tick();
            check($sformatf("%s[%0d]", vecs[i].tag, i), 32'(outs), 32'(vecs[i].exp));
        end

        // Reset in the middle of the strobe phase, then a clean cycle with latency checks.
        @(negedge sysClk);
        drive(1'b0, 1'b0, P_RD16);
        for (int i = 0; i < 4; i++) tick();
        check("hs_in_strobe", 32'(outs), 32'(O_RD));
        @(negedge sysClk);
        sysReset = 1'b1;
        tick();
        check("hs_reset", 32'(outs), 32'(O_IDLE));
        @(negedge sysClk);
        drive(1'b0, 1'b1, P_RD16);
        tick();
        check("hs_post_reset", 32'(outs), 32'(O_IDLE));

        @(negedge sysClk);
        nAS = 1'b0;
        nDS = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            tick();
            k++;
            seen = dsackOe;
        end
        check("hs_dsack_seen", 32'(seen), 32'd1);
        check("hs_dsack_lat", 32'(k), 32'd9);
        check("hs_dsack_val", 32'(nDsackOut), 32'b01);

        @(negedge sysClk);
        nAS = 1'b1;
        nDS = 1'b1;
        tick();
        check("hs_negate", 32'({nIORd, dsackOe, nDsackOut, nIdeCS1}), 32'b1_0_11_0);
        k = 0;
        while (nIdeCS1 == 1'b0 && k < 20) begin
            tick();
            k++;
        end
        check("hs_cs_hold", 32'(k), 32'd2);

`ifdef MEZ_BUS_WATCHDOG_EN
        // Unclaimed non-IDE access: berr on the 16th sampled-low edge.
        @(negedge sysClk);
        drive(1'b0, 1'b0, P_NOIDE);
        nDsackIn = 2'b11;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) check("wd_before", 32'(berrOe), 32'd0);
            if (i == 16) check("wd_fire", 32'(berrOe), 32'd1);
        end
        @(negedge sysClk);
        nAS = 1'b1;
        nDS = 1'b1;
        tick();
        check("wd_clear", 32'(berrOe), 32'd0);

        // Claimed at cycle 10: no timeout however long nAS stays low.
        @(negedge sysClk);
        nAS = 1'b0;
        nDS = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 10) begin
                @(negedge sysClk);
                nDsackIn = 2'b01;
            end
            tick();
            if (berrOe) seen = 1'b1;
        end
        check("wd_claimed", 32'(seen), 32'd0);
        @(negedge sysClk);
        nAS = 1'b1;
        nDS = 1'b1;
        nDsackIn = 2'b11;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
